imem_ctrl: RTL and testbench
============================

IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 Parameter ADDR_BITS, default 10, word-address width; DEPTH = 2**ADDR_BITS words.
REQ-002 Parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 Parameter CLEAR_ON_RESET, default 1; 1 = zero-sweep array after reset, 0 = no sweep.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  reset, synchronous, active-low.
REQ-006 fetch_req  in  1  fetch request valid.
REQ-007 fetch_addr  in  ADDR_BITS  word address of fetch.
REQ-008 fetch_ready  out  1  request accepted when fetch_req && fetch_ready.
REQ-009 rsp_valid  out  1  rsp_data holds fetched word.
REQ-010 rsp_data  out  DATA_WIDTH  fetched instruction.
REQ-011 rsp_ready  in  1  consumer takes response when rsp_valid && rsp_ready.
REQ-012 prog_we  in  1  program-port write strobe.
REQ-013 prog_addr  in  ADDR_BITS  program write word address.
REQ-014 prog_data  in  DATA_WIDTH  program write data.
REQ-015 busy  out  1  high while reset asserted or clear sweep running.

Function
REQ-016 FSM states: CLEAR, RUN; reset forces CLEAR with sweep counter 0.
REQ-017 CLEAR: each cycle writes 0 to address counter, counter += 1; at counter = DEPTH-1 the write completes and next state is RUN (exactly DEPTH cycles after reset release).
REQ-018 CLEAR_ON_RESET = 0: reset forces RUN directly; array contents unchanged by reset; busy low after first cycle with reset high.
REQ-019 busy = 1 in CLEAR or while reset low, else 0.
REQ-020 fetch_ready = (state == RUN) && (!rsp_valid || rsp_ready).
REQ-021 Accepted fetch: rsp_valid = 1 and rsp_data = mem[fetch_addr] on next rising edge (1-cycle latency).
REQ-022 Back-to-back: with rsp_ready held 1, one fetch accepted and one response delivered per cycle.
REQ-023 Backpressure: rsp_valid && !rsp_ready holds rsp_valid and rsp_data stable; no new fetch accepted.
REQ-024 rsp_valid clears on edge where response consumed and no new fetch accepted.
REQ-025 prog_we in RUN writes prog_data to mem[prog_addr] on rising edge.
REQ-026 prog_we in CLEAR or while reset low: ignored, no array write.
REQ-027 Same-cycle fetch and prog write to same address: response returns old word (read-before-write); following fetch returns new word.
REQ-028 fetch_addr/prog_addr full range 0..DEPTH-1 valid; no out-of-range case exists.
REQ-029 Fetch requests presented while fetch_ready low are not accepted and produce no response.

Reset
REQ-030 Reset low: rsp_valid = 0, rsp_data = 0, fetch_ready = 0, busy = 1, state = CLEAR (or RUN per REQ-018 once released).
REQ-031 Reset mid-sweep restarts sweep from address 0; reset with response pending discards it.
REQ-032 No output is undefined after the first clock edge with reset low.

Structure
REQ-033 Package imem_pkg holds state enum (CLEAR, RUN) and default parameter constants (ADDR_BITS, DATA_WIDTH).
REQ-034 Sub-module imem_array: single write port, single synchronous read port, read-before-write, DEPTH x DATA_WIDTH; imem_ctrl muxes sweep vs program write onto its write port.

Verification
REQ-035 Reset low 3 cycles, release, CLEAR_ON_RESET=1, ADDR_BITS=4 -> busy high exactly 16 cycles after release, then fetch of each of 0..15 returns 0.
REQ-036 Program addr 5 = 0xDEADBEEF, fetch 5 with rsp_ready=1 -> rsp_valid next cycle, rsp_data = 0xDEADBEEF.
REQ-037 Fetch 1,2,3 back-to-back (pre-programmed 0x11,0x22,0x33), rsp_ready low 2 cycles after first response -> 0x11 held stable, fetch_ready low, then 0x22, 0x33 delivered in order, none lost or duplicated.
REQ-038 Same cycle: fetch 7 and prog write 7 = 0xA5A5A5A5 (old 0x12345678) -> response 0x12345678; next fetch 7 -> 0xA5A5A5A5.
REQ-039 prog_we asserted during sweep to addr 3 = 0xFFFFFFFF -> after sweep, fetch 3 returns 0.
REQ-040 Reset asserted at sweep count 8 with response pending -> rsp_valid 0 next edge, sweep restarts at 0, busy high full DEPTH cycles after release.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and default geometry for the instruction-memory controller.
// Imported by imem_array and imem_ctrl.
package imem_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int DEF_ADDR_BITS  = 10;
   localparam int DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one write port, one registered read port.
// A read and a write to the same address on one edge return the old word.
module imem_array
   import imem_pkg::*;
#(
   parameter int ADDR_BITS  = DEF_ADDR_BITS,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [ADDR_BITS-1:0]  wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  re,
   input  logic [ADDR_BITS-1:0]  rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_r;

   // storage write port; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // read register sees the pre-write contents on a same-edge collision
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_data_r <= '0;
      end else if (re) begin
         rd_data_r <= mem_r[rd_addr];
      end
   end

   assign rd_data = rd_data_r;

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: optional zero sweep after reset, then
// single-cycle fetches with a valid/ready response and a program write port.
module imem_ctrl
   import imem_pkg::*;
#(
   parameter int ADDR_BITS      = DEF_ADDR_BITS,
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_req,
   input  logic [ADDR_BITS-1:0]  fetch_addr,
   output logic                  fetch_ready,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   input  logic                  rsp_ready,
   input  logic                  prog_we,
   input  logic [ADDR_BITS-1:0]  prog_addr,
   input  logic [DATA_WIDTH-1:0] prog_data,
   output logic                  busy
);

   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] LAST_ADDR   = ADDR_BITS'(DEPTH - 1);
   localparam state_t               RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

   state_t                state_r;
   state_t                state_nxt_s;
   logic [ADDR_BITS-1:0]  sweep_cnt_r;
   logic [ADDR_BITS-1:0]  sweep_cnt_nxt_s;
   logic                  rsp_valid_r;
   logic                  rsp_valid_nxt_s;
   logic                  busy_r;
   logic                  fetch_ready_s;
   logic                  fetch_accept_s;
   logic                  mem_we_s;
   logic [ADDR_BITS-1:0]  mem_waddr_s;
   logic [DATA_WIDTH-1:0] mem_wdata_s;

   // a new fetch may enter only when the response slot is free or draining
   assign fetch_ready_s  = reset && (state_r == RUN) && (!rsp_valid_r || rsp_ready);
   assign fetch_accept_s = fetch_req && fetch_ready_s;

   // next-state, sweep counter and write-port mux between sweep and program port
   always_comb begin
      state_nxt_s     = state_r;
      sweep_cnt_nxt_s = sweep_cnt_r;
      mem_we_s        = 1'b0;
      mem_waddr_s     = prog_addr;
      mem_wdata_s     = prog_data;
      case (state_r)
         CLEAR: begin
            if (CLEAR_ON_RESET != 0) begin
               mem_we_s    = 1'b1;
               mem_waddr_s = sweep_cnt_r;
               mem_wdata_s = '0;
               if (sweep_cnt_r == LAST_ADDR) begin
                  state_nxt_s     = RUN;
                  sweep_cnt_nxt_s = '0;
               end else begin
                  sweep_cnt_nxt_s = sweep_cnt_r + ADDR_BITS'(1);
               end
            end else begin
               state_nxt_s = RUN;
            end
         end
         RUN: begin
            mem_we_s = prog_we;
         end
         default: begin
            state_nxt_s     = CLEAR;
            sweep_cnt_nxt_s = '0;
         end
      endcase
      // the array must never be written while reset is held
      if (!reset) begin
         mem_we_s = 1'b0;
      end else begin
         mem_we_s = mem_we_s;
      end
   end

   // response slot: load on accept, drop when consumed, otherwise hold
   always_comb begin
      rsp_valid_nxt_s = rsp_valid_r;
      if (fetch_accept_s) begin
         rsp_valid_nxt_s = 1'b1;
      end else if (rsp_ready) begin
         rsp_valid_nxt_s = 1'b0;
      end else begin
         rsp_valid_nxt_s = rsp_valid_r;
      end
   end

   // control state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r     <= RESET_STATE;
         sweep_cnt_r <= '0;
         rsp_valid_r <= 1'b0;
         busy_r      <= 1'b1;
      end else begin
         state_r     <= state_nxt_s;
         sweep_cnt_r <= sweep_cnt_nxt_s;
         rsp_valid_r <= rsp_valid_nxt_s;
         busy_r      <= (state_nxt_s == CLEAR);
      end
   end

   imem_array #(
      .ADDR_BITS  (ADDR_BITS),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_array (
      .clk     (clk),
      .reset   (reset),
      .we      (mem_we_s),
      .wr_addr (mem_waddr_s),
      .wr_data (mem_wdata_s),
      .re      (fetch_accept_s),
      .rd_addr (fetch_addr),
      .rd_data (rsp_data)
   );

   assign fetch_ready = fetch_ready_s;
   assign rsp_valid   = rsp_valid_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_imem_ctrl.sv
// Bench for imem_ctrl (ADDR_BITS=4): directed scenarios followed by random
// traffic, all checked against an abstract memory/response model.
module tb_imem_ctrl;

   localparam int AB    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 16;

   logic          clk        = 1'b0;
   logic          reset      = 1'b0;
   logic          fetch_req  = 1'b0;
   logic [AB-1:0] fetch_addr = '0;
   logic          fetch_ready;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          rsp_ready  = 1'b0;
   logic          prog_we    = 1'b0;
   logic [AB-1:0] prog_addr  = '0;
   logic [DW-1:0] prog_data  = '0;
   logic          busy;

   int checks = 0;
   int errors = 0;

   // abstract model: word array, run flag, remaining sweep cycles, response slot
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_run        = 1'b0;
   int            m_clear_left = DEPTH;
   logic          m_valid      = 1'b0;
   logic [DW-1:0] m_data       = '0;

   always #5 clk = ~clk;

   imem_ctrl #(
      .ADDR_BITS      (AB),
      .DATA_WIDTH     (DW),
      .CLEAR_ON_RESET (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_ready (fetch_ready),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .rsp_ready   (rsp_ready),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one clock: drive at negedge, check ready, advance model at posedge, check outputs
   task automatic step(input logic rst_v, input logic fr, input logic [AB-1:0] fa,
                       input logic rr, input logic pw, input logic [AB-1:0] pa,
                       input logic [DW-1:0] pd);
      logic exp_ready;
      reset      = rst_v;
      fetch_req  = fr;
      fetch_addr = fa;
      rsp_ready  = rr;
      prog_we    = pw;
      prog_addr  = pa;
      prog_data  = pd;
      #1;
      exp_ready = rst_v && m_run && (!m_valid || rr);
      check("fetch_ready", {31'd0, fetch_ready}, {31'd0, exp_ready});
      @(posedge clk);
      if (!rst_v) begin
         m_run        = 1'b0;
         m_clear_left = DEPTH;
         m_valid      = 1'b0;
         m_data       = '0;
      end else if (!m_run) begin
         m_clear_left--;
         if (m_clear_left == 0) begin
            m_run = 1'b1;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
         end
      end else begin
         if (fr && exp_ready) begin
            m_valid = 1'b1;
            m_data  = m_mem[fa];
         end else if (rr) begin
            m_valid = 1'b0;
         end
         if (pw) m_mem[pa] = pd;
      end
      @(negedge clk);
      check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
      check("rsp_data", rsp_data, m_data);
      check("busy", {31'd0, busy}, {31'd0, !m_run});
   endtask

   task automatic idle(input logic rr);
      step(1'b1, 1'b0, 4'd0, rr, 1'b0, 4'd0, 32'd0);
   endtask

   initial begin
      int n;
      @(negedge clk);

      // reset held for three cycles
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 4'd2, 32'h1);
      check("reset_busy", {31'd0, busy}, 32'd1);

      // sweep length after release; a program write during the sweep is dropped
      n = 0;
      do begin
         step(1'b1, 1'b0, 4'd0, 1'b1, (n == 0), 4'd3, 32'hFFFF_FFFF);
         n++;
      end while (busy && n < 40);
      check("sweep_len", n, 32'd16);

      // every word reads zero after the sweep
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 1'b1, 4'(i), 1'b1, 1'b0, 4'd0, 32'd0);
         check("clear_word", rsp_data, 32'd0);
      end
      idle(1'b1);

      // program then fetch one word
      step(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd5, 32'hDEAD_BEEF);
      step(1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 32'd0);
      check("fetch5_valid", {31'd0, rsp_valid}, 32'd1);
      check("fetch5_data", rsp_data, 32'hDEAD_BEEF);

      step(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 32'h11);
      step(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 32'h22);
      step(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 32'h33);
      step(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd7, 32'h1234_5678);

      // back-to-back fetches with two cycles of backpressure on the first response
      step(1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 4'd0, 32'd0);
      check("bp_first", rsp_data, 32'h11);
      step(1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 4'd0, 32'd0);
      check("bp_hold1", rsp_data, 32'h11);
      step(1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 4'd0, 32'd0);
      check("bp_hold2", rsp_data, 32'h11);
      step(1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 32'd0);
      check("bp_second", rsp_data, 32'h22);
      step(1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 32'd0);
      check("bp_third", rsp_data, 32'h33);
      idle(1'b1);
      check("bp_drained", {31'd0, rsp_valid}, 32'd0);

      // same-edge fetch and write to one address
      step(1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 4'd7, 32'hA5A5_A5A5);
      check("rbw_old", rsp_data, 32'h1234_5678);
      step(1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 4'd0, 32'd0);
      check("rbw_new", rsp_data, 32'hA5A5_A5A5);

      // reset with a response pending, then reset again mid-sweep
      step(1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 4'd0, 32'd0);
      check("pending", {31'd0, rsp_valid}, 32'd1);
      step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0);
      check("pending_dropped", {31'd0, rsp_valid}, 32'd0);
      for (int i = 0; i < 8; i++) idle(1'b1);
      check("mid_sweep_busy", {31'd0, busy}, 32'd1);
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0);
      n = 0;
      do begin
         idle(1'b1);
         n++;
      end while (busy && n < 40);
      check("resweep_len", n, 32'd16);

      // random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) != 0), 1'($urandom), 4'($urandom),
              ($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), 32'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
